// File: rtl/maxpool_pkg.sv
// Shared types and helpers for the max-pool stream controller.
package maxpool_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int POOL_LAT = 3;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// One-row pixel store: single write port, asynchronous read, no reset on storage.
module pool_line_buf
  import maxpool_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 28
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic [cnt_w(IMG_W)-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic [cnt_w(IMG_W)-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0]       rd_data
);

  logic [DATA_WIDTH-1:0] mem [IMG_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/maxpool_ctrl.sv
// Raster-stream sequencer for a free-running 2x2 max-pool datapath.
// Optional MAXPOOL_CTRL_COORD_EN adds out_col/out_row/out_ch tags aligned with out_valid.
module maxpool_ctrl
  import maxpool_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int CHANNELS   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] pool_line_1,
  output logic [DATA_WIDTH-1:0] pool_line_2,
  input  logic [DATA_WIDTH-1:0] pool_max,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done
`ifdef MAXPOOL_CTRL_COORD_EN
  ,
  output logic [cnt_w(IMG_W/2)-1:0] out_col,
  output logic [cnt_w(IMG_H/2)-1:0] out_row,
  output logic [cnt_w(CHANNELS)-1:0] out_ch
`endif
);

  localparam int COL_W = cnt_w(IMG_W);
  localparam int ROW_W = cnt_w(IMG_H);
  localparam int CH_W  = cnt_w(CHANNELS);

  if ((IMG_W % 2) != 0 || IMG_W < 2) begin : g_bad_w
    $error("maxpool_ctrl: IMG_W must be even and at least 2");
  end
  if ((IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_h
    $error("maxpool_ctrl: IMG_H must be even and at least 2");
  end

  state_t                 state;
  logic [COL_W-1:0]       col;
  logic [ROW_W-1:0]       row;
  logic [CH_W-1:0]        ch;
  logic                   pend;
  logic                   vld_p0, vld_p1, vld_p2;
  logic [DATA_WIDTH-1:0]  hold_top, hold_bot, next_top, next_bot;
  logic [DATA_WIDTH-1:0]  lb_rd;
  logic                   acc, issue;

  assign acc   = in_valid && in_ready;
  assign issue = acc && row[0] && col[0];

  pool_line_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .IMG_W      (IMG_W)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (acc && !row[0]),
    .wr_addr (col),
    .wr_data (in_data),
    .rd_addr (col),
    .rd_data (lb_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      col         <= '0;
      row         <= '0;
      ch          <= '0;
      pend        <= 1'b0;
      vld_p0      <= 1'b0;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      pool_line_1 <= '0;
      pool_line_2 <= '0;
    end else begin
      done   <= 1'b0;
      pend   <= issue;
      // Strobe is seeded when the second column of a pair reaches the pool.
      vld_p0 <= pend;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      if (pend) begin
        pool_line_1 <= next_top;
        pool_line_2 <= next_bot;
      end
      if (issue) begin
        pool_line_1 <= hold_top;
        pool_line_2 <= hold_bot;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          if (acc) begin
            if (col == COL_W'(IMG_W - 1)) begin
              col <= '0;
              if (row == ROW_W'(IMG_H - 1)) begin
                row <= '0;
                if (ch == CH_W'(CHANNELS - 1)) begin
                  ch       <= '0;
                  state    <= DRAIN;
                  in_ready <= 1'b0;
                end else begin
                  ch <= ch + 1'b1;
                end
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!pend && !vld_p0 && !vld_p1 && !vld_p2) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pair holding registers: data only, qualified by the control path.
  always_ff @(posedge clk) begin
    if (acc && row[0]) begin
      if (!col[0]) begin
        hold_top <= lb_rd;
        hold_bot <= in_data;
      end else begin
        next_top <= lb_rd;
        next_bot <= in_data;
      end
    end
  end

  assign out_valid = vld_p2;
  assign out_data  = vld_p2 ? pool_max : '0;

`ifdef MAXPOOL_CTRL_COORD_EN
  localparam int OC_W = cnt_w(IMG_W/2);
  localparam int OR_W = cnt_w(IMG_H/2);

  logic [OC_W-1:0] col_is, col_p0, col_p1, col_p2;
  logic [OR_W-1:0] row_is, row_p0, row_p1, row_p2;
  logic [CH_W-1:0] ch_is,  ch_p0,  ch_p1,  ch_p2;

  // Coordinates follow the same three-stage path as the valid strobe.
  always_ff @(posedge clk) begin
    if (issue) begin
      col_is <= OC_W'(col >> 1);
      row_is <= OR_W'(row >> 1);
      ch_is  <= ch;
    end
    col_p0 <= col_is;  col_p1 <= col_p0;  col_p2 <= col_p1;
    row_p0 <= row_is;  row_p1 <= row_p0;  row_p2 <= row_p1;
    ch_p0  <= ch_is;   ch_p1  <= ch_p0;   ch_p2  <= ch_p1;
  end

  assign out_col = col_p2;
  assign out_row = row_p2;
  assign out_ch  = ch_p2;
`endif

endmodule

// File: tb/tb_maxpool_ctrl.sv
// Directed scoreboard bench for maxpool_ctrl with a behavioural 2x2 pool model.
module tb_maxpool_ctrl;
  import maxpool_pkg::*;

  localparam int DW   = 8;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int C    = 2;
  localparam int NOUT = (W/2) * (H/2) * C;

  logic          clk, rst, start, in_valid, in_ready;
  logic [DW-1:0] in_data, pool_line_1, pool_line_2, pool_max, out_data;
  logic          out_valid, busy, done;
`ifdef MAXPOOL_CTRL_COORD_EN
  logic [cnt_w(W/2)-1:0] out_col;
  logic [cnt_w(H/2)-1:0] out_row;
  logic [cnt_w(C)-1:0]   out_ch;
`endif

  maxpool_ctrl #(
    .DATA_WIDTH (DW),
    .IMG_W      (W),
    .IMG_H      (H),
    .CHANNELS   (C)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .pool_line_1 (pool_line_1),
    .pool_line_2 (pool_line_2),
    .pool_max    (pool_max),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .busy        (busy),
    .done        (done)
`ifdef MAXPOOL_CTRL_COORD_EN
    ,
    .out_col     (out_col),
    .out_row     (out_row),
    .out_ch      (out_ch)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running pool: column max, then max of two consecutive column maxima.
  logic [DW-1:0] cm, cm_d;
  always @(posedge clk) begin
    cm       <= (pool_line_1 > pool_line_2) ? pool_line_1 : pool_line_2;
    cm_d     <= cm;
    pool_max <= (cm > cm_d) ? cm : cm_d;
  end

  typedef struct {
    logic [DW-1:0] d;
    int            c;
    int            r;
    int            k;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] pix [C][H][W];
  int            n_chk, n_pass, done_cnt, out_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] max4(input logic [DW-1:0] a, b, c, d);
    logic [DW-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        done_cnt++;
        chk("done_busy_low", 32'(busy), 32'd0);
      end
      if (out_valid) begin
        out_cnt++;
        if (q.size() == 0) begin
          chk("out_unexpected", 32'(out_valid), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_data", 32'(out_data), 32'(e.d));
`ifdef MAXPOOL_CTRL_COORD_EN
          chk("out_col", 32'(out_col), 32'(e.c));
          chk("out_row", 32'(out_row), 32'(e.r));
          chk("out_ch",  32'(out_ch),  32'(e.k));
`endif
        end
      end
    end
  end

  task automatic fill_directed();
    logic [DW-1:0] rows [4][4];
    rows = '{'{8'd1, 8'd9, 8'd3, 8'd4}, '{8'd5, 8'd2, 8'd8, 8'd7},
             '{8'd10, 8'd0, 8'd255, 8'd254}, '{8'd3, 8'd200, 8'd201, 8'd7}};
    for (int k = 0; k < C; k++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          pix[k][r][c] = (k == 0) ? rows[r][c] : DW'(r * 40 + c * 17 + 3);
  endtask

  task automatic fill_random();
    for (int k = 0; k < C; k++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          pix[k][r][c] = DW'($urandom_range(0, 255));
  endtask

  // mode 0: continuous, 1: one idle cycle between pixels, 2: random gaps.
  task automatic drive_frame(input int mode, input int stop_at, input bit spur);
    int   idx, b;
    exp_t e;
    idx = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < C; k++) begin
      for (int r = 0; r < H; r++) begin
        for (int c = 0; c < W; c++) begin
          if (idx == stop_at) return;
          if (mode == 1 && idx > 0) @(negedge clk);
          if (mode == 2) repeat ($urandom_range(0, 2)) @(negedge clk);
          in_valid = 1'b1;
          in_data  = pix[k][r][c];
          start    = spur && (idx == 5);
          b = 0;
          while (!in_ready && b < 20) begin
            @(negedge clk);
            b++;
          end
          if (b >= 20) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            start    = 1'b0;
            return;
          end
          chk("busy_run", 32'(busy), 32'd1);
          @(posedge clk);
          if ((r % 2) == 1 && (c % 2) == 1) begin
            e.d = max4(pix[k][r-1][c-1], pix[k][r-1][c], pix[k][r][c-1], pix[k][r][c]);
            e.c = c / 2;
            e.r = r / 2;
            e.k = k;
            q.push_back(e);
          end
          @(negedge clk);
          in_valid = 1'b0;
          start    = 1'b0;
          idx++;
        end
      end
    end
  endtask

  // Cycle-exact tail after the last accepted pixel (cycle t = column 2k on pool ports).
  task automatic check_tail();
    chk("tail_l1_even", 32'(pool_line_1), 32'(pix[C-1][H-2][W-2]));
    chk("tail_l2_even", 32'(pool_line_2), 32'(pix[C-1][H-1][W-2]));
    chk("tail_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("tail_l1_odd", 32'(pool_line_1), 32'(pix[C-1][H-2][W-1]));
    chk("tail_l2_odd", 32'(pool_line_2), 32'(pix[C-1][H-1][W-1]));
    @(negedge clk);
    chk("tail_vld_t2", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("tail_vld_t3", 32'(out_valid), 32'd1);
    chk("tail_done_t3", 32'(done), 32'd0);
    @(negedge clk);
    chk("tail_vld_t4", 32'(out_valid), 32'd0);
    chk("tail_done_t4", 32'(done), 32'd0);
    chk("tail_busy_t4", 32'(busy), 32'd1);
    @(negedge clk);
    chk("tail_done_t5", 32'(done), 32'd1);
    chk("tail_busy_t5", 32'(busy), 32'd0);
    @(negedge clk);
    chk("tail_done_t6", 32'(done), 32'd0);
  endtask

  task automatic end_frame(input int d0, input int o0);
    repeat (8) @(negedge clk);
    chk("frame_done_once", 32'(done_cnt), 32'(d0 + 1));
    chk("frame_out_count", 32'(out_cnt), 32'(o0 + NOUT));
    chk("frame_queue_empty", 32'(q.size()), 32'd0);
    chk("frame_busy_low", 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_line_1"}, 32'(pool_line_1), 32'd0);
    chk({tag, "_line_2"}, 32'(pool_line_2), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, o0;
    n_chk = 0; n_pass = 0; done_cnt = 0; out_cnt = 0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    fill_directed();
    d0 = done_cnt; o0 = out_cnt;
    drive_frame(0, -1, 1'b0);
    check_tail();
    end_frame(d0, o0);

    d0 = done_cnt; o0 = out_cnt;
    drive_frame(1, -1, 1'b0);
    check_tail();
    end_frame(d0, o0);

    fill_random();
    d0 = done_cnt; o0 = out_cnt;
    drive_frame(2, -1, 1'b0);
    check_tail();
    end_frame(d0, o0);

    // Reset while a pair is being presented on an odd row.
    fill_random();
    drive_frame(0, C*H*W - W + 2, 1'b0);
    d0 = done_cnt; o0 = out_cnt;
    in_valid = 1'b1;
    in_data  = pix[C-1][H-1][2];
    rst      = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    rst      = 1'b0;
    in_valid = 1'b0;
    q.delete();
    repeat (10) @(negedge clk);
    chk("midreset_no_done", 32'(done_cnt), 32'(d0));
    chk("midreset_no_out", 32'(out_cnt), 32'(o0));

    // Pixels offered while idle are refused.
    in_valid = 1'b1;
    in_data  = 8'h55;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_ready_low", 32'(in_ready), 32'd0);
      chk("idle_busy_low", 32'(busy), 32'd0);
    end
    in_valid = 1'b0;

    // Full frame after reset, with a spurious start pulse mid-frame.
    fill_random();
    d0 = done_cnt; o0 = out_cnt;
    drive_frame(2, -1, 1'b1);
    end_frame(d0, o0);

    fill_random();
    d0 = done_cnt; o0 = out_cnt;
    drive_frame(0, -1, 1'b0);
    end_frame(d0, o0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
